// File: rtl/stage_pack.sv
// stage_pack: single-issue valid/ready input packed into a 2-entry buffer that
// feeds a dual-issue stage FIFO write port. Optional pairing wait: STAGE_PACK_PAIR_WAIT_EN.
module stage_pack #(
    parameter int Width   = 32,
    parameter int MaxWait = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             drain_i,
    input  logic             in_valid_i,
    input  logic [Width-1:0] in_data_i,
    output logic             in_rdy_o,
    output logic [1:0]       out_valid_o,
    output logic [Width-1:0] out_data0_o,
    output logic [Width-1:0] out_data1_o,
    input  logic [1:0]       out_rdy_i
);

    logic [Width-1:0] buf_q [2];
    logic [Width-1:0] buf_d [2];
    logic [1:0]       cnt_q, cnt_d, n_out, base;
    logic [3:0]       wait_q;
    logic             present1, take0, take1, n_in;

`ifdef STAGE_PACK_PAIR_WAIT_EN
    logic [3:0] wait_d;

    assign present1 = (wait_q >= 4'(MaxWait)) | drain_i;

    always_comb begin
        wait_d = '0;
        if (cnt_d == 2'd1 && n_out == 2'd0 && !n_in)
            wait_d = (wait_q == 4'hf) ? wait_q : wait_q + 4'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      wait_q <= '0;
        else if (flush_i) wait_q <= '0;
        else              wait_q <= wait_d;
    end
`else
    logic [4:0] unused_wait;

    assign present1    = 1'b1;
    assign wait_q      = '0;
    assign unused_wait = {wait_q, drain_i};
`endif

    always_comb begin
        unique case (cnt_q)
            2'd0:    out_valid_o = 2'b00;
            2'd1:    out_valid_o = {1'b0, present1};
            default: out_valid_o = 2'b11;
        endcase
    end

    // Slot 1 only counts when slot 0 also goes: rdy 10 takes nothing.
    assign take0    = out_valid_o[0] & out_rdy_i[0];
    assign take1    = out_valid_o[1] & out_rdy_i[1] & out_rdy_i[0];
    assign n_out    = 2'(take0) + 2'(take1);
    assign in_rdy_o = ~flush_i & ((cnt_q < 2'd2) | (n_out != 2'd0));
    assign n_in     = in_valid_i & in_rdy_o;
    assign base     = cnt_q - n_out;
    assign cnt_d    = cnt_q - n_out + 2'(n_in);

    always_comb begin
        buf_d = buf_q;
        if (n_out == 2'd1) buf_d[0] = buf_q[1];
        if (n_in) begin
            if (base == 2'd0) buf_d[0] = in_data_i;
            else              buf_d[1] = in_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            cnt_q <= flush_i ? 2'd0 : cnt_d;
            buf_q <= buf_d;
        end
    end

    assign out_data0_o = buf_q[0];
    assign out_data1_o = buf_q[1];

endmodule

// File: tb/tb_stage_pack.sv
// Directed vector bench for stage_pack: per-cycle table plus hand sequences
// for lone-entry latency and asynchronous reset.
module tb_stage_pack;

    localparam int W  = 32;
    localparam int MW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0, drain = 1'b0, in_v = 1'b0;
    logic [W-1:0]  in_d = '0;
    logic          in_rdy;
    logic [1:0]    out_v;
    logic [W-1:0]  d0, d1;
    logic [1:0]    rdy = 2'b00;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         flush;
        logic         in_v;
        logic [W-1:0] in_d;
        logic [1:0]   rdy;
        logic         e_rdy;
        logic [1:0]   e_vld;
        logic [W-1:0] e_d0;
        logic [W-1:0] e_d1;
    } vec_t;

    vec_t vecs[$];

    stage_pack #(.Width(W), .MaxWait(MW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .drain_i(drain),
        .in_valid_i(in_v), .in_data_i(in_d), .in_rdy_o(in_rdy),
        .out_valid_o(out_v), .out_data0_o(d0), .out_data1_o(d1),
        .out_rdy_i(rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic f, input logic v, input logic [W-1:0] d, input logic [1:0] r,
                       input logic er, input logic [1:0] ev, input logic [W-1:0] e0,
                       input logic [W-1:0] e1);
        vec_t t;
        t.flush = f; t.in_v = v; t.in_d = d; t.rdy = r;
        t.e_rdy = er; t.e_vld = ev; t.e_d0 = e0; t.e_d1 = e1;
        vecs.push_back(t);
    endtask

    task automatic lone(input logic drn, input int exp_lat, input string name);
        int lat;
        bit found;
        @(negedge clk);
        drain = drn; in_v = 1'b1; in_d = 32'h5a; rdy = 2'b11;
        @(posedge clk);
        @(negedge clk);
        in_v = 1'b0; lat = 1; found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            #1;
            if (out_v == 2'b01) found = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk({name, "_lat"}, found ? 32'(lat) : 32'hffff_ffff, 32'(exp_lat));
        chk({name, "_data"}, d0, 32'h5a);
        @(negedge clk);
        drain = 1'b0;
        #1 chk({name, "_gone"}, 32'(out_v), 32'h0);
    endtask

    initial begin
        // Streaming 0..7 with rdy 11: one entry in, one entry out each cycle.
        add(0, 1, 0, 2'b11, 1, 2'b00, 0, 0);
        for (int i = 1; i < 8; i++) add(0, 1, i, 2'b11, 1, 2'b01, i - 1, 0);
        add(0, 0, 0, 2'b11, 1, 2'b01, 7, 0);
        // Backpressure: fill A,B, stall 3 cycles, then take one (partial accept with C).
        add(0, 1, 'ha0, 2'b00, 1, 2'b00, 0, 0);
        add(0, 1, 'hb0, 2'b00, 1, 2'b01, 'ha0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 'hc0, 2'b00, 0, 2'b11, 'ha0, 'hb0);
        add(0, 1, 'hc0, 2'b01, 1, 2'b11, 'ha0, 'hb0);
        add(0, 0, 0, 2'b00, 0, 2'b11, 'hb0, 'hc0);
        // Illegal rdy 10 consumes nothing.
        add(0, 1, 'hd0, 2'b10, 0, 2'b11, 'hb0, 'hc0);
        add(0, 0, 0, 2'b00, 0, 2'b11, 'hb0, 'hc0);
        // Flush while full with input pending.
        add(1, 1, 'hd0, 2'b11, 0, 2'b11, 'hb0, 'hc0);
        add(0, 0, 0, 2'b11, 1, 2'b00, 0, 0);
        // Lone entries and a dual take.
        add(0, 1, 'he0, 2'b11, 1, 2'b00, 0, 0);
        add(0, 1, 'hf0, 2'b11, 1, 2'b01, 'he0, 0);
        add(0, 0, 0, 2'b11, 1, 2'b01, 'hf0, 0);
        add(0, 1, 'h10, 2'b00, 1, 2'b00, 0, 0);
        add(0, 1, 'h20, 2'b00, 1, 2'b01, 'h10, 0);
        add(0, 1, 'h30, 2'b11, 1, 2'b11, 'h10, 'h20);
        add(0, 0, 0, 2'b00, 1, 2'b01, 'h30, 0);
        add(0, 0, 0, 2'b01, 1, 2'b01, 'h30, 0);
        add(0, 0, 0, 2'b00, 1, 2'b00, 0, 0);

        #2;
        chk("rst_vld", 32'(out_v), 32'h0);
        chk("rst_d0", d0, 32'h0);
        chk("rst_d1", d1, 32'h0);
        chk("rst_in_rdy", 32'(in_rdy), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            flush = vecs[i].flush; in_v = vecs[i].in_v; in_d = vecs[i].in_d; rdy = vecs[i].rdy;
            #2;
            chk($sformatf("v%0d_in_rdy", i), 32'(in_rdy), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_vld", i), 32'(out_v), 32'(vecs[i].e_vld));
            if (vecs[i].e_vld[0]) chk($sformatf("v%0d_d0", i), d0, vecs[i].e_d0);
            if (vecs[i].e_vld[1]) chk($sformatf("v%0d_d1", i), d1, vecs[i].e_d1);
            @(negedge clk);
        end
        flush = 1'b0; in_v = 1'b0; rdy = 2'b00;

`ifdef STAGE_PACK_PAIR_WAIT_EN
        lone(1'b0, 1 + MW, "lone");
`else
        lone(1'b0, 1, "lone");
`endif
        lone(1'b1, 1, "lone_drain");

        // Asynchronous reset with the buffer full.
        @(negedge clk);
        in_v = 1'b1; in_d = 32'h11; rdy = 2'b00;
        @(negedge clk);
        in_d = 32'h22;
        @(negedge clk);
        in_v = 1'b0;
        #1 chk("pre_rst_vld", 32'(out_v), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld", 32'(out_v), 32'h0);
        chk("async_rst_d0", d0, 32'h0);
        chk("async_rst_d1", d1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_in_rdy", 32'(in_rdy), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
